// File: rtl/edgeconv_pkg.sv
//==========================================================================
// edgeconv_pkg : Sobel weights, width helpers and saturation for edgeconv
// Revision 1.0
//==========================================================================
`default_nettype none

package edgeconv_pkg;

    localparam int C_SOBEL_W_EDGE = 1;
    localparam int C_SOBEL_W_MID  = 2;

    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

    function automatic int mag_w(input int pix_w);
        return pix_w + 4;
    endfunction

    function automatic logic [31:0] saturate(input logic [31:0] mag, input int pix_w);
        logic [31:0] max_v;
        max_v = (32'd1 << pix_w) - 32'd1;
        return (mag > max_v) ? max_v : mag;
    endfunction

endpackage

`default_nettype wire

// File: rtl/edgeconv_linebuf.sv
//==========================================================================
// edgeconv_linebuf : two-row IMG_W x PIX_W shift buffer, async read
// Revision 1.0
//==========================================================================
`default_nettype none

module edgeconv_linebuf
    import edgeconv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(IMG_W)-1:0] col_i,
    input  logic [PIX_W-1:0]         din_i,
    output logic [PIX_W-1:0]         rd0_o,
    output logic [PIX_W-1:0]         rd1_o
);

    // Contents are deliberately not reset; the row counter gates their use.
    logic [PIX_W-1:0] buf0_q [IMG_W];
    logic [PIX_W-1:0] buf1_q [IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            buf1_q[col_i] <= buf0_q[col_i];
            buf0_q[col_i] <= din_i;
        end
    end

    assign rd0_o = buf0_q[col_i];
    assign rd1_o = buf1_q[col_i];

endmodule

`default_nettype wire

// File: rtl/edgeconv_sobel_stream.sv
//==========================================================================
// edgeconv_sobel_stream : streaming 3x3 Sobel |Gx|+|Gy| with valid/ready
// Optional binary output when EDGECONV_THRESH_EN is defined. Revision 1.0
//==========================================================================
`default_nettype none

module edgeconv_sobel_stream
    import edgeconv_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PIX_W  = 8,
    parameter int THRESH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] pixel_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] edge_out,
    output logic             out_last
);

    localparam int c_grad_w = grad_w(PIX_W);
    localparam int c_mag_w  = mag_w(PIX_W);
    localparam int c_col_w  = $clog2(IMG_W);
    localparam int c_row_w  = $clog2(IMG_H);
    localparam logic [c_col_w-1:0]  c_col_last = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0]  c_row_last = c_row_w'(IMG_H - 1);
    localparam logic [c_grad_w-1:0] c_w_edge   = c_grad_w'(C_SOBEL_W_EDGE);
    localparam logic [c_grad_w-1:0] c_w_mid    = c_grad_w'(C_SOBEL_W_MID);

    if (IMG_W < 3 || IMG_H < 3 || PIX_W < 1 || THRESH < 0) begin : g_param_check
        $error("edgeconv_sobel_stream: illegal parameter set");
    end

    function automatic logic [c_grad_w-1:0] wsum(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] m,
                                                 input logic [PIX_W-1:0] b);
        return c_grad_w'(a) * c_w_edge + c_grad_w'(m) * c_w_mid + c_grad_w'(b) * c_w_edge;
    endfunction

    function automatic logic [c_grad_w-1:0] absv(input logic [c_grad_w-1:0] g);
        return g[c_grad_w-1] ? -g : g;
    endfunction

    logic [c_col_w-1:0]        col_q, col_d, w_col;
    logic [c_row_w-1:0]        row_q, row_d, w_row;
    logic [2:0][PIX_W-1:0]     win1_q, win2_q;   // [0]=top, [1]=mid, [2]=bottom
    logic                      out_valid_q, out_valid_d;
    logic [PIX_W-1:0]          edge_q, edge_d;
    logic                      last_q, last_d;
    logic                      w_accept, w_sof, w_gen, w_last;
    logic [PIX_W-1:0]          w_top, w_mid, w_edge;
    logic [c_grad_w-1:0]       w_gx, w_gy;
    logic [c_mag_w-1:0]        w_mag;

    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_sof    = in_valid && in_sof;
    assign w_col    = w_sof ? '0 : col_q;
    assign w_row    = w_sof ? '0 : row_q;
    assign w_gen    = w_accept && (w_row >= c_row_w'(2)) && (w_col >= c_col_w'(2));
    assign w_last   = (w_row == c_row_last) && (w_col == c_col_last);

    edgeconv_linebuf #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W)
    ) u_linebuf (
        .clk     (clk),
        .wr_en_i (w_accept),
        .col_i   (w_col),
        .din_i   (pixel_in),
        .rd0_o   (w_mid),
        .rd1_o   (w_top)
    );

    // Left column is c-2 (win2), centre c-1 (win1), right is the live column.
    assign w_gx  = wsum(w_top, w_mid, pixel_in) - wsum(win2_q[0], win2_q[1], win2_q[2]);
    assign w_gy  = wsum(win2_q[2], win1_q[2], pixel_in) - wsum(win2_q[0], win1_q[0], w_top);
    assign w_mag = c_mag_w'(absv(w_gx)) + c_mag_w'(absv(w_gy));

`ifdef EDGECONV_THRESH_EN
    assign w_edge = (w_mag >= c_mag_w'(THRESH)) ? {PIX_W{1'b1}} : '0;
`else
    assign w_edge = PIX_W'(saturate(32'(w_mag), PIX_W));
`endif

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        edge_d      = edge_q;
        last_d      = last_q;
        if (w_accept) begin
            if (w_col == c_col_last) begin
                col_d = '0;
                row_d = (w_row == c_row_last) ? '0 : w_row + c_row_w'(1);
            end else begin
                col_d = w_col + c_col_w'(1);
                row_d = w_row;
            end
        end
        // Output register only moves when the slot is empty or being popped.
        if (in_ready) begin
            out_valid_d = w_gen;
            last_d      = w_gen && w_last;
            if (w_gen) begin
                edge_d = w_edge;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win1_q      <= '0;
            win2_q      <= '0;
            out_valid_q <= 1'b0;
            edge_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            edge_q      <= edge_d;
            last_q      <= last_d;
            if (w_accept) begin
                win2_q <= win1_q;
                win1_q <= {pixel_in, w_mid, w_top};
            end
        end
    end

    assign out_valid = out_valid_q;
    assign edge_out  = edge_q;
    assign out_last  = last_q;

endmodule

`default_nettype wire

// File: doc/edgeconv_sobel_stream.md
# edgeconv_sobel_stream

Parametrised streaming 3x3 Sobel edge-magnitude filter for the edgeconv pixel path. It accepts raster-order pixels under valid/ready flow control and buffers two image lines. For every interior pixel it emits a saturated |Gx|+|Gy| magnitude, with a last-pixel marker. It is the generalised successor to the fixed 8-bit, fixed-size edgeconv front end: image size and pixel width are configurable, and it adds backpressure, frame resync and an optional binary threshold.

## Interface
- IMG_W, 28: pixels per line, minimum 3
- IMG_H, 28: lines per frame, minimum 3
- PIX_W, 8: pixel and magnitude width in bits
- THRESH, 64: binarisation threshold, used only when thresholding is compiled in
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel_in valid
- in_ready  out  1  block can accept a pixel this cycle
- in_sof  in  1  qualified by in_valid; this pixel is (row 0, col 0)
- pixel_in  in  PIX_W  unsigned pixel
- out_valid  out  1  edge_out valid
- out_ready  in  1  downstream accepts edge_out
- edge_out  out  PIX_W  edge magnitude
- out_last  out  1  with out_valid; final interior pixel of the frame

## Operation
- A pixel is accepted when in_valid && in_ready.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accepted pixel.
  - col wraps to 0 and row increments.
  - After (IMG_H-1, IMG_W-1), both wrap to 0.
- in_sof on an accepted pixel forces that pixel to (0,0). The counters then continue from (0,1), and line-buffer contents are treated as stale: no outputs until row reaches 2 again.
- Two line buffers of IMG_W entries each hold rows r-1 and r-2, indexed by col. Reads are asynchronous; on accept, buffer1[col] <= buffer0[col] and buffer0[col] <= pixel_in.
- Window registers hold columns c-1 and c-2. The current column is {buffer1[col], buffer0[col], pixel_in}.
- Output generation: an accepted pixel with row>=2 and col>=2 produces one output for the centre at (row-1, col-1). Frame output count is (IMG_W-2)*(IMG_H-2). Border pixels produce nothing.
- Arithmetic:
  - Gx = (right column) - (left column), weighted 1,2,1 top to bottom.
  - Gy = (bottom row) - (top row), weighted 1,2,1 left to right.
  - Gx and Gy are signed, PIX_W+3 bits.
  - mag = |Gx|+|Gy|, unsigned PIX_W+4 bits.
  - edge_out = min(mag, 2^PIX_W-1).
- out_last is asserted with the output generated by accepted pixel (IMG_H-1, IMG_W-1).
- Window columns do not span line wrap: outputs at col<2 are suppressed, so stale window contents are never emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, edge_out=0, out_last=0, col=0, row=0, window registers 0. Line buffers are not reset; outputs are suppressed until they are refilled.
- Latency: an output generated by the pixel accepted at edge k is valid from edge k (out_valid high in cycle k+1).
- in_ready = !out_valid || out_ready, combinational. No input is taken while a stalled output is held.
- edge_out and out_last hold stable while out_valid && !out_ready.
- Simultaneous pop and push (out_ready high while a new output is generated) gives back-to-back out_valid with no bubble. Full throughput is one pixel per cycle.
- An accepted border pixel with out_ready high clears out_valid on the next cycle.
- Reset asserted mid-frame: all state returns to reset values immediately. The next frame must begin at (0,0), with or without in_sof.

## Configuration
- EDGECONV_THRESH_EN defined: edge_out = (mag >= THRESH) ? 2^PIX_W-1 : 0. The comparison uses the unsaturated mag.
- EDGECONV_THRESH_EN undefined: the saturated magnitude is output and THRESH is ignored, with no comparator logic.

## Structure
- edgeconv_pkg holds:
  - Sobel weight constants.
  - Width helper constants (GRAD_W = PIX_W+3, MAG_W = PIX_W+4) as parameter-derived localparams or functions.
  - A saturate function.
- The sub-module is edgeconv_linebuf: IMG_W x PIX_W two-row shift buffer with async read, write on accept.
- Counters, window, Sobel datapath and output register live in the top module.

## Test plan
All scenarios use IMG_W=8, IMG_H=6, PIX_W=8, out_ready=1 unless noted.
- Flat frame, all pixels 50 -> exactly 24 outputs, all 0; out_last only on the 24th.
- Vertical step, cols 0-3 = 0 and cols 4-7 = 255 -> centres at col 3 and 4 give 255 (mag 1020 saturated); all other outputs 0.
- Horizontal ramp, pixel = col*10 -> every output 80 (Gx=80, Gy=0).
- Backpressure: out_ready low for 5 cycles mid-frame -> in_ready low throughout; edge_out and out_last held; no output lost or duplicated; total count 24.
- in_sof asserted at pixel 20 of a frame, then 48 pixels of a new ramp frame -> no outputs before new row 2; then 24 outputs of 80.
- Reset asserted after 30 pixels, then a full step frame -> 24 outputs matching the step case.
- With EDGECONV_THRESH_EN and THRESH=100: ramp frame gives all 0; step frame gives 255 at cols 3 and 4 and 0 elsewhere.
